// File: rtl/cim_accum_ctrl.sv
// Read-modify-write sequencer: PE tile -> fetch partial sum -> CIM add -> write back.
// Latency: write + ready 4 cycles after accept (2 on first-channel/forwarded tiles).
// Backpressure: holds the PE with pe_ready_o low until write-back; optional bypass via CIM_FWD_EN.
module cim_accum_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 512,
    parameter int RD_TIMEOUT = 15,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              pe_valid_i,
    output logic              pe_ready_o,
    input  logic [ADDR_W-1:0] pe_addr_i,
    input  logic              pe_first_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic              mem_rd_valid_i,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic [DATA_W-1:0] cim_mem_o,
    input  logic [DATA_W-1:0] cim_result_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  tile_cnt_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        ADD  = 3'd3,
        WR   = 3'd4
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(RD_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [3:0]        tmo_cnt;
    logic [CNT_W-1:0]  tile_cnt;
    logic              err_q;

    logic accept;
    logic op_clr;
    logic op_ld_mem;
    logic op_ld_fwd;
    logic tmo_clr;
    logic tmo_inc;
    logic abort;
    logic wr_ld;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

`ifdef CIM_FWD_EN
    logic              fwd_vld;
    logic [ADDR_W-1:0] fwd_addr;

    // Last completed write; an abort invalidates it so a stale word is never reused.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fwd_vld  <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
        end else if (abort) begin
            fwd_vld  <= 1'b0;
        end else if (state == WR) begin
            fwd_vld  <= 1'b1;
            fwd_addr <= addr_q;
            fwd_data <= wr_data_q;
        end
    end

    assign fwd_hit = fwd_vld && (fwd_addr == pe_addr_i) && !pe_first_i;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        op_clr    = 1'b0;
        op_ld_mem = 1'b0;
        op_ld_fwd = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        abort     = 1'b0;
        wr_ld     = 1'b0;
        case (state)
            IDLE: begin
                if (pe_valid_i) begin
                    accept = 1'b1;
                    if (pe_first_i) begin
                        op_clr    = 1'b1;
                        state_nxt = ADD;
                    end else if (fwd_hit) begin
                        op_ld_fwd = 1'b1;
                        state_nxt = ADD;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                tmo_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rd_valid_i) begin
                    op_ld_mem = 1'b1;
                    state_nxt = ADD;
                end else if (tmo_cnt == TMO_LAST) begin
                    // Abort after RD_TIMEOUT empty WAIT cycles; the PE re-presents the tile.
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ADD: begin
                wr_ld     = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q    <= '0;
            operand_q <= '0;
            wr_data_q <= '0;
            tmo_cnt   <= '0;
            tile_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= pe_addr_i;
            end
            if (op_clr) begin
                operand_q <= '0;
            end else if (op_ld_mem) begin
                operand_q <= mem_rd_data_i;
            end else if (op_ld_fwd) begin
                operand_q <= fwd_data;
            end
            if (wr_ld) begin
                wr_data_q <= cim_result_i;
            end
            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end
            if (state == WR) begin
                tile_cnt <= tile_cnt + CNT_W'(1);
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pe_ready_o    = (state == WR);
    assign mem_wr_en_o   = (state == WR);
    assign mem_rd_en_o   = (state == RD);
    assign mem_rd_addr_o = addr_q;
    assign mem_wr_addr_o = addr_q;
    assign mem_wr_data_o = wr_data_q;
    assign cim_mem_o     = operand_q;
    assign busy_o        = (state != IDLE);
    assign tile_cnt_o    = tile_cnt;
    assign err_o         = err_q;

endmodule
